// File: rtl/enc_pkg.sv
// Shared types and defaults for the 4-to-2 sequential request encoder.
// Elaboration-time helpers keep the line count and address width consistent.
package enc_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StValid = 1'b1
    } state_e;

    localparam int unsigned NDef  = 4;
    localparam int unsigned AwDef = 2;

    // True only when n is an exact power of two addressed by aw bits.
    function automatic bit dims_ok(input int unsigned n, input int unsigned aw);
        return (aw == $clog2(n)) && (n == (32'd1 << aw));
    endfunction

    localparam bit DefDimsOk = dims_ok(NDef, AwDef);

endpackage

// File: rtl/req_encoder_4x2_if.sv
// Request/response bundle between the request encoder and its producer/consumer.
// The master side is the encoder; the slave side drives requests and ready.
interface req_encoder_4x2_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned AW = 2
);
    logic          en;
    logic [N-1:0]  req;
    logic          ready;
    logic          ovr_clr;
    logic          valid;
    logic [AW-1:0] addr;
    logic [N-1:0]  pending;
    logic          overrun;

    modport master (
        input  en,
        input  req,
        input  ready,
        input  ovr_clr,
        output valid,
        output addr,
        output pending,
        output overrun
    );

    modport slave (
        output en,
        output req,
        output ready,
        output ovr_clr,
        input  valid,
        input  addr,
        input  pending,
        input  overrun
    );
endinterface

// File: rtl/prio_enc_lsb.sv
// Combinational priority encoder: the lowest set bit index wins.
// any_o flags that at least one bit is set; idx_o is 0 when none are.
module prio_enc_lsb #(
    parameter int unsigned N  = 4,
    parameter int unsigned AW = $clog2(N)
) (
    input  logic [N-1:0]  vec_i,
    output logic [AW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
        // Walk from the top down so the lowest index is the last (winning) write.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = AW'(i);
            end
        end
    end

endmodule

// File: rtl/req_encoder_4x2.sv
// Sequential 4-to-2 request encoder: sticky pending capture, lowest-index priority,
// and a registered valid/ready delivery of the encoded line address.
module req_encoder_4x2
    import enc_pkg::*;
#(
    parameter int unsigned N  = NDef,
    parameter int unsigned AW = AwDef
) (
    input logic            clk,
    input logic            rst_n,
    req_encoder_4x2_if.master bus
);

    if (!dims_ok(N, AW)) begin : g_bad_dims
        $error("req_encoder_4x2: N must equal 2**AW");
    end

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [N-1:0]  pending_q, pending_d;
    logic          overrun_q, overrun_d;

    logic [N-1:0]  set_vec;
    logic [N-1:0]  clr_mask;
    logic [N-1:0]  rem;
    logic          fire;
    logic [AW-1:0] pend_idx, rem_idx;
    logic          pend_any, rem_any;

    assign fire    = (state_q == StValid) && bus.ready;
    assign set_vec = bus.req & {N{bus.en}};
    assign rem     = pending_q & ~clr_mask;

    always_comb begin
        clr_mask = '0;
        if (fire) begin
            clr_mask[addr_q] = 1'b1;
        end
    end

    prio_enc_lsb #(
        .N  (N),
        .AW (AW)
    ) u_prio_pending (
        .vec_i (pending_q),
        .idx_o (pend_idx),
        .any_o (pend_any)
    );

    // rem deliberately excludes same-edge arrivals so delivery order stays registered.
    prio_enc_lsb #(
        .N  (N),
        .AW (AW)
    ) u_prio_rem (
        .vec_i (rem),
        .idx_o (rem_idx),
        .any_o (rem_any)
    );

    always_comb begin
        pending_d = rem | set_vec;
        overrun_d = overrun_q;
        if (|(set_vec & rem)) begin
            overrun_d = 1'b1;
        end else if (bus.ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                if (pend_any) begin
                    addr_d  = pend_idx;
                    state_d = StValid;
                end
            end
            StValid: begin
                if (bus.ready) begin
                    if (rem_any) begin
                        addr_d = rem_idx;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            pending_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.valid   = (state_q == StValid);
    assign bus.addr    = addr_q;
    assign bus.pending = pending_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_req_encoder_4x2.sv
// Directed, table-driven bench for req_encoder_4x2 with hand-computed expectations,
// plus hand-written reset and asynchronous-reset sequences.
module tb_req_encoder_4x2;

    typedef struct {
        string      name;
        logic       en;
        logic [3:0] req;
        logic       ready;
        logic       ovr_clr;
        logic       v;
        logic [1:0] a;
        logic [3:0] p;
        logic       o;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t tbl[$];

    req_encoder_4x2_if #(.N(4), .AW(2)) bus ();

    req_encoder_4x2 #(
        .N  (4),
        .AW (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input logic v, input logic [1:0] a,
                            input logic [3:0] p, input logic o);
        chk({nm, ".valid"}, 32'(bus.valid), 32'(v));
        if (v) chk({nm, ".addr"}, 32'(bus.addr), 32'(a));
        chk({nm, ".pending"}, 32'(bus.pending), 32'(p));
        chk({nm, ".overrun"}, 32'(bus.overrun), 32'(o));
    endtask

    task automatic drive(input logic en, input logic [3:0] req, input logic rdy,
                         input logic oc);
        bus.en      = en;
        bus.req     = req;
        bus.ready   = rdy;
        bus.ovr_clr = oc;
    endtask

    // Each row: inputs applied before an edge, outputs expected just after it.
    task automatic add(input string nm, input logic en, input logic [3:0] req,
                       input logic rdy, input logic oc, input logic v, input logic [1:0] a,
                       input logic [3:0] p, input logic o);
        tbl.push_back('{nm, en, req, rdy, oc, v, a, p, o});
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // reset and single request
        add("single_cap",   1, 4'b0100, 0, 0, 0, 0, 4'b0100, 0);
        add("single_valid", 1, 4'b0000, 0, 0, 1, 2, 4'b0100, 0);
        add("single_ack",   1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        // priority, back-to-back with ready held
        add("b2b_cap",      1, 4'b1010, 1, 0, 0, 0, 4'b1010, 0);
        add("b2b_addr1",    1, 4'b0000, 1, 0, 1, 1, 4'b1010, 0);
        add("b2b_addr3",    1, 4'b0000, 1, 0, 1, 3, 4'b1000, 0);
        add("b2b_done",     1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        // stall, no preemption
        add("stall_cap",    1, 4'b1000, 0, 0, 0, 0, 4'b1000, 0);
        add("stall_v3",     1, 4'b0000, 0, 0, 1, 3, 4'b1000, 0);
        add("stall_hi",     1, 4'b0001, 0, 0, 1, 3, 4'b1001, 0);
        add("stall_hold",   1, 4'b0000, 0, 0, 1, 3, 4'b1001, 0);
        add("stall_next0",  1, 4'b0000, 1, 0, 1, 0, 4'b0001, 0);
        add("stall_done",   1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        // overrun
        add("ovr_cap",      1, 4'b0100, 0, 0, 0, 0, 4'b0100, 0);
        add("ovr_set",      1, 4'b0100, 0, 0, 1, 2, 4'b0100, 1);
        add("ovr_sticky",   1, 4'b0000, 0, 0, 1, 2, 4'b0100, 1);
        add("ovr_clear",    1, 4'b0000, 0, 1, 1, 2, 4'b0100, 0);
        // collision: set in the handshake cycle keeps the line pending, no overrun
        add("coll_edge",    1, 4'b0100, 1, 0, 0, 0, 4'b0100, 0);
        add("coll_again",   1, 4'b0000, 0, 0, 1, 2, 4'b0100, 0);
        add("coll_done",    1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        // overrun set beats ovr_clr in the same cycle
        add("setwin_cap",   1, 4'b0001, 0, 0, 0, 0, 4'b0001, 0);
        add("setwin_both",  1, 4'b0001, 0, 1, 1, 0, 4'b0001, 1);
        add("setwin_clr",   1, 4'b0000, 0, 1, 1, 0, 4'b0001, 0);
        add("setwin_done",  1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        // en gating from an empty state
        add("en0_a",        0, 4'b1111, 0, 0, 0, 0, 4'b0000, 0);
        add("en0_b",        0, 4'b1111, 0, 0, 0, 0, 4'b0000, 0);
        add("en0_c",        0, 4'b1111, 0, 0, 0, 0, 4'b0000, 0);
        // en=0 does not disturb delivery of an already pending line
        add("en_cap",       1, 4'b0010, 0, 0, 0, 0, 4'b0010, 0);
        add("en_off_v",     0, 4'b1111, 0, 0, 1, 1, 4'b0010, 0);
        add("en_off_hold",  0, 4'b1111, 0, 0, 1, 1, 4'b0010, 0);
        add("en_deliver",   1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);

        // reset held with requests active
        drive(1, 4'b1111, 0, 0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outs("reset", 0, 0, 4'b0000, 0);
        drive(1, 4'b0000, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_outs("post_reset", 0, 0, 4'b0000, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].req, tbl[i].ready, tbl[i].ovr_clr);
            @(posedge clk);
            #1;
            chk_outs(tbl[i].name, tbl[i].v, tbl[i].a, tbl[i].p, tbl[i].o);
        end

        // asynchronous reset mid-handshake: valid=1, addr=3, pending=1001
        drive(1, 4'b1000, 0, 0);
        @(posedge clk);
        #1;
        drive(1, 4'b0000, 0, 0);
        @(posedge clk);
        #1;
        drive(1, 4'b0001, 0, 0);
        @(posedge clk);
        #1;
        drive(1, 4'b0000, 0, 0);
        chk_outs("arst_setup", 1, 3, 4'b1001, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("arst_now", 0, 0, 4'b0000, 0);
        chk("arst_addr", 32'(bus.addr), 32'd0);
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_outs("arst_after", 0, 0, 4'b0000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_encoder_4x2.md
Name: req_encoder_4x2

Overview:
- Sequential 4-to-2 request encoder, the encode-side counterpart of the team's 2x4 address decoder.
- Captures single-cycle request pulses on 4 lines into sticky pending bits.
- Encodes the highest-priority pending line to a 2-bit address and presents it to a consumer over a valid/ready handshake.
- Used as the event/interrupt source that feeds address-driven blocks.

Parameters:
- N, 4, number of request lines.
- AW, 2, address width. Must equal clog2(N), and N must equal 2**AW; elaborate-time error otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  capture enable; when 0, new req pulses are ignored
- req  input  N  request pulses, one bit per line, sampled each rising edge
- ready  input  1  consumer accepts the current addr
- ovr_clr  input  1  synchronous clear of overrun
- valid  output  1  addr holds an undelivered request
- addr  output  AW  encoded line index
- pending  output  N  sticky pending bits (registered)
- overrun  output  1  sticky flag: a request was seen on a line already pending

Behaviour:
- Clock and reset
  - One clock: clk, rising edge.
  - Reset is asynchronous, active-low (rst_n). Asserting it mid-handshake drops everything immediately.
  - Reset values: valid=0, addr=0, pending=0, overrun=0, FSM=IDLE.
- Capture (every edge)
  - Set term: set = req & {N{en}}.
  - pending_next = (pending & ~clr_mask) | set.
  - clr_mask is one-hot at addr when valid&&ready, otherwise 0.
  - Collision: set wins over clear for the same bit. The line stays pending, and overrun is not raised.
- Overrun
  - overrun sets on any bit where set=1, pending=1 and clr_mask=0.
  - ovr_clr=1 clears overrun at the edge. If a set condition occurs in the same cycle, set wins.
- Priority
  - Lowest index wins: line 0 is highest priority, line N-1 lowest.
- FSM, two states: IDLE and VALID.
  - IDLE
    - valid=0.
    - If registered pending!=0 at an edge, load addr=prio(pending), go to VALID.
    - Latency: req pulse sampled at edge k sets pending at k; valid and addr appear after edge k+1 (2 edges req-to-valid).
  - VALID
    - valid=1.
    - addr and valid hold stable while ready=0. Priority never preempts a presented addr, even if a higher-priority line becomes pending.
    - On valid&&ready at an edge, let rem = pending & ~clr_mask. rem excludes set bits arriving at that same edge.
    - If rem!=0: load addr=prio(rem) and stay in VALID. This gives back-to-back delivery with no bubble.
    - If rem==0: valid=0, go to IDLE. Requests arriving at that same edge are presented after the following edge.
- en
  - Gates only capture.
  - Pending bits, delivery and the handshake continue while en=0.
- ready is don't-care while valid=0.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package enc_pkg contains:
  - state enum {IDLE, VALID}
  - default N/AW localparams
  - a clog2-check constant.
- One natural sub-module, prio_enc_lsb:
  - combinational, parameter N
  - input vector, output index plus any-set flag, lowest set index wins
  - instantiated twice: once on pending, once on rem.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111, en=1 → valid=0, addr=0, pending=0, overrun=0. Release and pulse req=4'b0100 for one cycle → pending=4'b0100 after 1 edge; valid=1, addr=2 after 2 edges; ready=1 for one cycle → valid=0, pending=0.
- Priority and back-to-back: single pulse req=4'b1010, ready held 1 → addr=1 then addr=3 on consecutive cycles with valid=1 throughout, then valid=0, pending=0.
- Stall and no preemption: ready=0, pulse req=4'b1000, later pulse req=4'b0001 → addr stays 3 while stalled. Raise ready → next addr=0.
- Overrun and collision:
  - Pulse req[2] twice while pending[2]=1, ready=0 → overrun=1; pulse ovr_clr → overrun=0.
  - Pulse req[2] in the handshake cycle of addr=2 → pending[2] stays 1, overrun stays 0, addr=2 presented again.
- en gating: en=0 with req=4'b1111 for 3 cycles → pending=0, valid=0. Set en=1 with existing pending=4'b0010 from before → delivery of addr=1 unaffected.
- Async reset mid-handshake: valid=1, addr=3, pending=4'b1001; drop rst_n between clock edges → all outputs 0 immediately, with no clk edge required.
